alu_rs: RTL and testbench

Reservation station that buffers decoded integer, branch and jump operations, tracks their outstanding register dependencies, and issues one operand-complete operation per cycle to the ALU. It sits between the decoder/issue stage and the ALU in the out-of-order core. It wakes up waiting operands by snooping the ALU and load/store result broadcasts by ROB position. It is flushed on `rollback`.

---
 rtl/alu_rs.sv | 199 +++++++++++++++++++
 tb/tb_alu_rs.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - reservation station that wakes up operands and issues ready ops to the ALU
// Lowest-index free entry allocates, and the lowest-index operand-complete entry dispatches.
module alu_rs #(
  parameter int RS_SIZE   = 16,
  parameter int ROB_POS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 issue_valid,
  input  logic [6:0]           issue_opcode,
  input  logic [2:0]           issue_funct3,
  input  logic                 issue_funct7,
  input  logic [31:0]          issue_val1,
  input  logic [31:0]          issue_val2,
  input  logic                 issue_has_dep1,
  input  logic                 issue_has_dep2,
  input  logic [ROB_POS_W-1:0] issue_dep1,
  input  logic [ROB_POS_W-1:0] issue_dep2,
  input  logic [31:0]          issue_imm,
  input  logic [31:0]          issue_pc,
  input  logic [ROB_POS_W-1:0] issue_rob_pos,
  output logic                 rs_full,
  input  logic                 alu_result,
  input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
  input  logic [31:0]          alu_result_val,
  input  logic                 lsb_result,
  input  logic [ROB_POS_W-1:0] lsb_result_rob_pos,
  input  logic [31:0]          lsb_result_val,
  output logic                 alu_en,
  output logic [6:0]           alu_opcode,
  output logic [2:0]           alu_funct3,
  output logic                 alu_funct7,
  output logic [31:0]          alu_val1,
  output logic [31:0]          alu_val2,
  output logic [31:0]          alu_imm,
  output logic [31:0]          alu_pc,
  output logic [ROB_POS_W-1:0] alu_rob_pos
);
  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]   busy, rdy1, rdy2;
  logic [6:0]           e_opcode [RS_SIZE];
  logic [2:0]           e_funct3 [RS_SIZE];
  logic                 e_funct7 [RS_SIZE];
  logic [31:0]          e_val1   [RS_SIZE];
  logic [31:0]          e_val2   [RS_SIZE];
  logic [ROB_POS_W-1:0] e_dep1   [RS_SIZE];
  logic [ROB_POS_W-1:0] e_dep2   [RS_SIZE];
  logic [31:0]          e_imm    [RS_SIZE];
  logic [31:0]          e_pc     [RS_SIZE];
  logic [ROB_POS_W-1:0] e_rob    [RS_SIZE];

  logic             free_found, sel_found, go, alloc;
  logic [IDX_W-1:0] free_idx, sel_idx;
  logic [RS_SIZE-1:0] wake1, wake2;
  logic [31:0]      wval1 [RS_SIZE];
  logic [31:0]      wval2 [RS_SIZE];
  logic             new_rdy1, new_rdy2;
  logic [31:0]      new_val1, new_val2;

  assign rs_full = &busy;
  assign go      = rdy && !rollback;
  assign alloc   = go && issue_valid && free_found;

  // Descending scan so the last hit is the lowest index.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (busy[i] && rdy1[i] && rdy2[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // ALU broadcast takes precedence when both tags hit the same operand.
  always_comb begin
    wake1 = '0;
    wake2 = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      wval1[i] = alu_result_val;
      wval2[i] = alu_result_val;
      if (busy[i] && !rdy1[i]) begin
        if (alu_result && e_dep1[i] == alu_result_rob_pos) begin
          wake1[i] = 1'b1;
        end else if (lsb_result && e_dep1[i] == lsb_result_rob_pos) begin
          wake1[i] = 1'b1;
          wval1[i] = lsb_result_val;
        end
      end
      if (busy[i] && !rdy2[i]) begin
        if (alu_result && e_dep2[i] == alu_result_rob_pos) begin
          wake2[i] = 1'b1;
        end else if (lsb_result && e_dep2[i] == lsb_result_rob_pos) begin
          wake2[i] = 1'b1;
          wval2[i] = lsb_result_val;
        end
      end
    end
  end

  always_comb begin
    new_val1 = issue_val1;
    new_rdy1 = !issue_has_dep1;
    new_val2 = issue_val2;
    new_rdy2 = !issue_has_dep2;
    if (issue_has_dep1) begin
      if (alu_result && issue_dep1 == alu_result_rob_pos) begin
        new_val1 = alu_result_val;
        new_rdy1 = 1'b1;
      end else if (lsb_result && issue_dep1 == lsb_result_rob_pos) begin
        new_val1 = lsb_result_val;
        new_rdy1 = 1'b1;
      end
    end
    if (issue_has_dep2) begin
      if (alu_result && issue_dep2 == alu_result_rob_pos) begin
        new_val2 = alu_result_val;
        new_rdy2 = 1'b1;
      end else if (lsb_result && issue_dep2 == lsb_result_rob_pos) begin
        new_val2 = lsb_result_val;
        new_rdy2 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= '0;
      rdy1        <= '0;
      rdy2        <= '0;
      alu_en      <= 1'b0;
      alu_opcode  <= '0;
      alu_funct3  <= '0;
      alu_funct7  <= 1'b0;
      alu_val1    <= '0;
      alu_val2    <= '0;
      alu_imm     <= '0;
      alu_pc      <= '0;
      alu_rob_pos <= '0;
    end else if (rdy) begin
      if (rollback) begin
        busy   <= '0;
        alu_en <= 1'b0;
      end else begin
        alu_en <= sel_found;
        rdy1   <= rdy1 | wake1;
        rdy2   <= rdy2 | wake2;
        if (sel_found) begin
          busy[sel_idx] <= 1'b0;
          alu_opcode    <= e_opcode[sel_idx];
          alu_funct3    <= e_funct3[sel_idx];
          alu_funct7    <= e_funct7[sel_idx];
          alu_val1      <= e_val1[sel_idx];
          alu_val2      <= e_val2[sel_idx];
          alu_imm       <= e_imm[sel_idx];
          alu_pc        <= e_pc[sel_idx];
          alu_rob_pos   <= e_rob[sel_idx];
        end
        if (alloc) begin
          busy[free_idx] <= 1'b1;
          rdy1[free_idx] <= new_rdy1;
          rdy2[free_idx] <= new_rdy2;
        end
      end
    end
  end

  // Entry payload carries no reset; it is only meaningful while busy is set.
  always_ff @(posedge clk) begin
    if (go) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (wake1[i]) e_val1[i] <= wval1[i];
        if (wake2[i]) e_val2[i] <= wval2[i];
      end
      if (alloc) begin
        e_opcode[free_idx] <= issue_opcode;
        e_funct3[free_idx] <= issue_funct3;
        e_funct7[free_idx] <= issue_funct7;
        e_val1[free_idx]   <= new_val1;
        e_val2[free_idx]   <= new_val2;
        e_dep1[free_idx]   <= issue_dep1;
        e_dep2[free_idx]   <= issue_dep2;
        e_imm[free_idx]    <= issue_imm;
        e_pc[free_idx]     <= issue_pc;
        e_rob[free_idx]    <= issue_rob_pos;
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - table-driven and scoreboard bench for alu_rs
module tb_alu_rs;
  logic        clk, rst, rdy, rollback, issue_valid;
  logic [6:0]  issue_opcode;
  logic [2:0]  issue_funct3;
  logic        issue_funct7;
  logic [31:0] issue_val1, issue_val2, issue_imm, issue_pc;
  logic        issue_has_dep1, issue_has_dep2;
  logic [3:0]  issue_dep1, issue_dep2, issue_rob_pos;
  logic        rs_full;
  logic        alu_result, lsb_result;
  logic [3:0]  alu_result_rob_pos, lsb_result_rob_pos;
  logic [31:0] alu_result_val, lsb_result_val;
  logic        alu_en;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic        alu_funct7;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [3:0]  alu_rob_pos;

  alu_rs #(.RS_SIZE(16), .ROB_POS_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .issue_valid(issue_valid), .issue_opcode(issue_opcode), .issue_funct3(issue_funct3),
    .issue_funct7(issue_funct7), .issue_val1(issue_val1), .issue_val2(issue_val2),
    .issue_has_dep1(issue_has_dep1), .issue_has_dep2(issue_has_dep2),
    .issue_dep1(issue_dep1), .issue_dep2(issue_dep2), .issue_imm(issue_imm),
    .issue_pc(issue_pc), .issue_rob_pos(issue_rob_pos), .rs_full(rs_full),
    .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos),
    .alu_result_val(alu_result_val), .lsb_result(lsb_result),
    .lsb_result_rob_pos(lsb_result_rob_pos), .lsb_result_val(lsb_result_val),
    .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
    .alu_funct7(alu_funct7), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
  );

  typedef struct {
    logic [3:0] rob; logic [6:0] op; logic [2:0] f3; logic f7;
    logic [31:0] v1, v2, imm, pc; int cyc;
  } exp_t;

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic f7;
    logic [31:0] v1; logic h1; logic [3:0] d1;
    logic [31:0] v2; logic h2; logic [3:0] d2;
    logic [31:0] imm, pc; logic [3:0] rob;
    logic av; logic [3:0] at; logic [31:0] aval;
    logic lv; logic [3:0] lt; logic [31:0] lval;
    logic [31:0] ev1, ev2;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[9];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU-accepted cycle: alu_en high while rdy is high (rdy only changes just after posedge).
  always @(negedge clk) begin
    if (!rst && rdy && alu_en) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_dispatch: got rob=%0d v1=%h v2=%h at cycle %0d, want no dispatch",
                 alu_rob_pos, alu_val1, alu_val2, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (alu_rob_pos !== e.rob || alu_opcode !== e.op || alu_funct3 !== e.f3 ||
            alu_funct7 !== e.f7 || alu_val1 !== e.v1 || alu_val2 !== e.v2 ||
            alu_imm !== e.imm || alu_pc !== e.pc || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL dispatch: got rob=%0d op=%h f3=%h f7=%b v1=%h v2=%h imm=%h pc=%h cyc=%0d, want rob=%0d op=%h f3=%h f7=%b v1=%h v2=%h imm=%h pc=%h cyc=%0d",
                   alu_rob_pos, alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2, alu_imm, alu_pc, cyc,
                   e.rob, e.op, e.f3, e.f7, e.v1, e.v2, e.imm, e.pc, e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    alu_result  = 1'b0;
    lsb_result  = 1'b0;
    rollback    = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic set_issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [31:0] v1, input logic h1, input logic [3:0] d1,
                           input logic [31:0] v2, input logic h2, input logic [3:0] d2,
                           input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
    issue_valid = 1'b1; issue_opcode = op; issue_funct3 = f3; issue_funct7 = f7;
    issue_val1 = v1; issue_has_dep1 = h1; issue_dep1 = d1;
    issue_val2 = v2; issue_has_dep2 = h2; issue_dep2 = d2;
    issue_imm = imm; issue_pc = pc; issue_rob_pos = rob;
  endtask

  task automatic push(input logic [3:0] rob, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                      input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                      input logic [31:0] pc, input int c);
    exp_t e;
    e.rob = rob; e.op = op; e.f3 = f3; e.f7 = f7;
    e.v1 = v1; e.v2 = v2; e.imm = imm; e.pc = pc; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d dispatches still pending want 0", sb.size());
      sb.delete();
    end
    repeat (3) tick();
  endtask

  initial begin
    int m;
    tbl[0] = '{7'h13, 3'd0, 1'b0, 32'd5,     1'b0, 4'd0,  32'd0,     1'b0, 4'd0, 32'd7,         32'h100, 4'd3,
               1'b0, 4'd0,  32'd0,      1'b0, 4'd0,  32'd0,      32'd5,      32'd0};
    tbl[1] = '{7'h33, 3'd0, 1'b0, 32'h11,    1'b0, 4'd0,  32'h22,    1'b0, 4'd0, 32'd0,         32'h104, 4'd4,
               1'b0, 4'd0,  32'd0,      1'b0, 4'd0,  32'd0,      32'h11,     32'h22};
    tbl[2] = '{7'h33, 3'd0, 1'b1, 32'd100,   1'b0, 4'd0,  32'd1,     1'b0, 4'd0, 32'd0,         32'h108, 4'd5,
               1'b0, 4'd0,  32'd0,      1'b0, 4'd0,  32'd0,      32'd100,    32'd1};
    tbl[3] = '{7'h63, 3'd0, 1'b0, 32'd7,     1'b0, 4'd0,  32'd7,     1'b0, 4'd0, 32'hFFFF_FFF0, 32'h200, 4'd6,
               1'b0, 4'd0,  32'd0,      1'b0, 4'd0,  32'd0,      32'd7,      32'd7};
    tbl[4] = '{7'h6F, 3'd0, 1'b0, 32'd0,     1'b0, 4'd0,  32'd0,     1'b0, 4'd0, 32'h800,       32'h204, 4'd7,
               1'b0, 4'd0,  32'd0,      1'b0, 4'd0,  32'd0,      32'd0,      32'd0};
    tbl[5] = '{7'h33, 3'd0, 1'b0, 32'd1,     1'b0, 4'd0,  32'hDEAD,  1'b1, 4'd5, 32'd0,         32'h208, 4'd8,
               1'b0, 4'd0,  32'd0,      1'b1, 4'd5,  32'hABCD,   32'd1,      32'hABCD};
    tbl[6] = '{7'h33, 3'd7, 1'b0, 32'hBAD,   1'b1, 4'd9,  32'd3,     1'b0, 4'd0, 32'd0,         32'h20C, 4'd10,
               1'b1, 4'd9,  32'h1234,   1'b0, 4'd0,  32'd0,      32'h1234,   32'd3};
    tbl[7] = '{7'h13, 3'd4, 1'b0, 32'hBAD,   1'b1, 4'd12, 32'd0,     1'b0, 4'd0, 32'd5,         32'h210, 4'd11,
               1'b1, 4'd12, 32'hAAAA,   1'b1, 4'd12, 32'hBBBB,   32'hAAAA,   32'd0};
    tbl[8] = '{7'h33, 3'd1, 1'b0, 32'h42,    1'b0, 4'd2,  32'h43,    1'b0, 4'd2, 32'd0,         32'h214, 4'd12,
               1'b1, 4'd2,  32'h999,    1'b1, 4'd2,  32'h888,    32'h42,     32'h43};

    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; issue_valid = 1'b0;
    set_issue(7'd0, 3'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    issue_valid = 1'b0;
    alu_result = 1'b0; alu_result_rob_pos = 4'd0; alu_result_val = 32'd0;
    lsb_result = 1'b0; lsb_result_rob_pos = 4'd0; lsb_result_val = 32'd0;
    #3;
    check("reset_alu_en", 32'(alu_en), 32'd0);
    check("reset_rs_full", 32'(rs_full), 32'd0);
    check("reset_alu_val1", alu_val1, 32'd0);
    check("reset_alu_pc", alu_pc, 32'd0);
    check("reset_alu_rob_pos", 32'(alu_rob_pos), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Table: ready ops and issue-time bypass, issued back to back
    for (int i = 0; i < 9; i++) begin
      set_issue(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].v1, tbl[i].h1, tbl[i].d1,
                tbl[i].v2, tbl[i].h2, tbl[i].d2, tbl[i].imm, tbl[i].pc, tbl[i].rob);
      alu_result = tbl[i].av; alu_result_rob_pos = tbl[i].at; alu_result_val = tbl[i].aval;
      lsb_result = tbl[i].lv; lsb_result_rob_pos = tbl[i].lt; lsb_result_val = tbl[i].lval;
      push(tbl[i].rob, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].ev1, tbl[i].ev2,
           tbl[i].imm, tbl[i].pc, cyc + 2);
      tick();
    end
    drain(20);

    // Wakeup by a later ALU broadcast
    set_issue(7'h33, 3'd0, 1'b0, 32'hBAD, 1'b1, 4'd2, 32'd9, 1'b0, 4'd0, 32'd0, 32'h300, 4'd4);
    tick();
    tick();
    alu_result = 1'b1; alu_result_rob_pos = 4'd2; alu_result_val = 32'h10;
    push(4'd4, 7'h33, 3'd0, 1'b0, 32'h10, 32'd9, 32'd0, 32'h300, cyc + 2);
    tick();
    drain(10);

    // ALU and LSB waking different operands, then both tags on one operand
    set_issue(7'h33, 3'd0, 1'b0, 32'd0, 1'b1, 4'd11, 32'd0, 1'b1, 4'd12, 32'd0, 32'h310, 4'd1);
    tick();
    set_issue(7'h33, 3'd0, 1'b0, 32'd0, 1'b1, 4'd13, 32'd5, 1'b0, 4'd0, 32'd0, 32'h314, 4'd2);
    tick();
    alu_result = 1'b1; alu_result_rob_pos = 4'd11; alu_result_val = 32'h111;
    lsb_result = 1'b1; lsb_result_rob_pos = 4'd12; lsb_result_val = 32'h222;
    push(4'd1, 7'h33, 3'd0, 1'b0, 32'h111, 32'h222, 32'd0, 32'h310, cyc + 2);
    tick();
    alu_result = 1'b1; alu_result_rob_pos = 4'd13; alu_result_val = 32'hAAAA;
    lsb_result = 1'b1; lsb_result_rob_pos = 4'd13; lsb_result_val = 32'hBBBB;
    push(4'd2, 7'h33, 3'd0, 1'b0, 32'hAAAA, 32'd5, 32'd0, 32'h314, cyc + 2);
    tick();
    drain(10);

    // Fill all 16 entries, drop a 17th, then release them with one broadcast
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) set_issue(7'h33, 3'd0, 1'b0, 32'd0, 1'b1, 4'd7, 32'(i), 1'b0, 4'd0, 32'd0, 32'(i * 4), 4'(i));
      else            set_issue(7'h33, 3'd0, 1'b0, 32'(i), 1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 32'd0, 32'(i * 4), 4'(i));
      tick();
    end
    check("full_after_16", 32'(rs_full), 32'd1);
    set_issue(7'h13, 3'd0, 1'b0, 32'hFFFF, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'h400, 4'd3);
    tick();
    check("full_after_drop", 32'(rs_full), 32'd1);
    lsb_result = 1'b1; lsb_result_rob_pos = 4'd7; lsb_result_val = 32'h77;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) push(4'(i), 7'h33, 3'd0, 1'b0, 32'h77, 32'(i), 32'd0, 32'(i * 4), cyc + 2 + i);
      else            push(4'(i), 7'h33, 3'd0, 1'b0, 32'(i), 32'h77, 32'd0, 32'(i * 4), cyc + 2 + i);
    end
    tick();
    check("full_while_waking", 32'(rs_full), 32'd1);
    tick();
    check("full_after_first_dispatch", 32'(rs_full), 32'd0);
    drain(30);

    // Rollback with entries busy, some ready and one in flight
    set_issue(7'h33, 3'd0, 1'b0, 32'd0, 1'b1, 4'd8, 32'd1, 1'b0, 4'd0, 32'd0, 32'h500, 4'd10);
    tick();
    set_issue(7'h33, 3'd0, 1'b0, 32'd0, 1'b1, 4'd8, 32'd2, 1'b0, 4'd0, 32'd0, 32'h504, 4'd11);
    tick();
    set_issue(7'h33, 3'd0, 1'b0, 32'd0, 1'b1, 4'd9, 32'd3, 1'b0, 4'd0, 32'd0, 32'h508, 4'd12);
    tick();
    set_issue(7'h33, 3'd0, 1'b0, 32'd4, 1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 32'd0, 32'h50C, 4'd13);
    tick();
    set_issue(7'h33, 3'd0, 1'b0, 32'd0, 1'b1, 4'd8, 32'd5, 1'b0, 4'd0, 32'd0, 32'h510, 4'd14);
    tick();
    alu_result = 1'b1; alu_result_rob_pos = 4'd8; alu_result_val = 32'h88;
    push(4'd10, 7'h33, 3'd0, 1'b0, 32'h88, 32'd1, 32'd0, 32'h500, cyc + 2);
    tick();
    tick();
    rollback = 1'b1;
    set_issue(7'h13, 3'd0, 1'b0, 32'd1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'h600, 4'd15);
    lsb_result = 1'b1; lsb_result_rob_pos = 4'd9; lsb_result_val = 32'h99;
    tick();
    check("rollback_alu_en", 32'(alu_en), 32'd0);
    check("rollback_rs_full", 32'(rs_full), 32'd0);
    alu_result = 1'b1; alu_result_rob_pos = 4'd8; alu_result_val = 32'h88;
    lsb_result = 1'b1; lsb_result_rob_pos = 4'd9; lsb_result_val = 32'h99;
    tick();
    repeat (4) tick();
    drain(1);

    // Stall with alu_en held high
    set_issue(7'h13, 3'd0, 1'b0, 32'h21, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd1, 32'h700, 4'd1);
    m = cyc;
    push(4'd1, 7'h13, 3'd0, 1'b0, 32'h21, 32'd0, 32'd1, 32'h700, m + 5);
    tick();
    set_issue(7'h13, 3'd0, 1'b0, 32'h22, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd2, 32'h704, 4'd2);
    push(4'd2, 7'h13, 3'd0, 1'b0, 32'h22, 32'd0, 32'd2, 32'h704, m + 6);
    tick();
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_alu_en", 32'(alu_en), 32'd1);
      check("stall_alu_rob_pos", 32'(alu_rob_pos), 32'd1);
    end
    rdy = 1'b1;
    drain(10);

    // Async reset while full
    for (int i = 0; i < 16; i++) begin
      set_issue(7'h33, 3'd0, 1'b0, 32'd0, 1'b1, 4'd6, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 4'(i));
      tick();
    end
    check("full_before_reset", 32'(rs_full), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_rs_full", 32'(rs_full), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Async reset while alu_en is held
    set_issue(7'h13, 3'd0, 1'b0, 32'h99, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'h800, 4'd9);
    tick();
    tick();
    rdy = 1'b0;
    check("pre_reset_alu_en", 32'(alu_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_alu_en", 32'(alu_en), 32'd0);
    check("async_reset_alu_val1", alu_val1, 32'd0);
    tick();
    rst = 1'b0;
    rdy = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
